// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: tracks per-register instruction attributes and
// produces PC hold, per-register hold/bubble enables and stall/flush counters.
module pipe_ctrl #(
   parameter int STAGES   = 4,
   parameter int MEM_STG  = 2,
   parameter int RA_W     = 4,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [RA_W-1:0]   id_src0,
   input  logic [RA_W-1:0]   id_src1,
   input  logic              id_use0,
   input  logic              id_use1,
   input  logic              id_we,
   input  logic              id_ld,
   input  logic              id_mem,
   input  logic              id_send,
   input  logic [RA_W-1:0]   id_dst,
   input  logic              ex_miss,
   input  logic              exc,
   input  logic              d_hit,
   input  logic              tx_full,
   output logic              pc_hold,
   output logic [STAGES-1:0] hold,
   output logic [STAGES-1:0] bubble,
   output logic [STAGES-1:0] valid,
   output logic [15:0]       stall_cnt,
   output logic [7:0]        flush_cnt
);

   // Reg 0 attributes are the live id_* decode; shadow copies start at reg 1.
   logic [STAGES-1:1]           we_s, ld_s, mem_s, send_s;
   logic [STAGES-1:1][RA_W-1:0] dst_s;
   logic                        mem_stall, tx_stall, lu_stall, miss_ok, flush_ev;
   int                          frz;
   logic                        unused_shadow;

   assign unused_shadow = ^{we_s, ld_s, mem_s, send_s, dst_s};

   always_comb begin
      mem_stall = valid[MEM_STG] & mem_s[MEM_STG] & ~d_hit;
      tx_stall  = valid[1] & send_s[1] & tx_full;
      lu_stall  = 1'b0;
      for (int k = 1; k < MEM_STG; k++) begin
         if (valid[k] && ld_s[k] && we_s[k] && ((ZERO_REG == 0) || (dst_s[k] != '0)) &&
             ((id_use0 && (id_src0 == dst_s[k])) || (id_use1 && (id_src1 == dst_s[k]))))
            lu_stall = 1'b1;
      end
      lu_stall = lu_stall & valid[0];
      miss_ok  = ex_miss & valid[1] & ~mem_stall & ~tx_stall;
   end

   always_comb begin
      hold     = '0;
      bubble   = '0;
      pc_hold  = 1'b0;
      flush_ev = 1'b0;
      frz      = mem_stall ? MEM_STG : (tx_stall ? 1 : 0);
      if (!rst) begin
         bubble = '1;
      end else if (exc) begin
         // Kill everything younger than MEM; the MEM instruction still completes.
         flush_ev = 1'b1;
         for (int i = 0; i < MEM_STG; i++) bubble[i] = 1'b1;
         if (mem_stall) begin
            hold[MEM_STG]     = 1'b1;
            bubble[MEM_STG+1] = 1'b1;
         end else begin
            bubble[MEM_STG] = 1'b1;
         end
      end else if (mem_stall || tx_stall || (lu_stall && !miss_ok)) begin
         pc_hold = 1'b1;
         for (int i = 0; i < STAGES; i++) begin
            hold[i]   = (i <= frz);
            bubble[i] = (i == frz + 1);
         end
      end else if (miss_ok) begin
         bubble[1:0] = 2'b11;
         flush_ev    = 1'b1;
      end else begin
         bubble[0] = ~if_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid     <= '0;
         we_s      <= '0;
         ld_s      <= '0;
         mem_s     <= '0;
         send_s    <= '0;
         dst_s     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!hold[0]) valid[0] <= ~bubble[0] & if_valid;
         if (!hold[1]) begin
            valid[1]  <= ~bubble[1] & valid[0];
            we_s[1]   <= ~bubble[1] & id_we;
            ld_s[1]   <= ~bubble[1] & id_ld;
            mem_s[1]  <= ~bubble[1] & id_mem;
            send_s[1] <= ~bubble[1] & id_send;
            dst_s[1]  <= bubble[1] ? '0 : id_dst;
         end
         for (int i = 2; i < STAGES; i++) begin
            if (!hold[i]) begin
               valid[i]  <= ~bubble[i] & valid[i-1];
               we_s[i]   <= ~bubble[i] & we_s[i-1];
               ld_s[i]   <= ~bubble[i] & ld_s[i-1];
               mem_s[i]  <= ~bubble[i] & mem_s[i-1];
               send_s[i] <= ~bubble[i] & send_s[i-1];
               dst_s[i]  <= bubble[i] ? '0 : dst_s[i-1];
            end
         end
         if (pc_hold && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         if (flush_ev && (flush_cnt != 8'hFF)) flush_cnt <= flush_cnt + 8'd1;
      end
   end

endmodule
